// File: rtl/r15_trace_capture.sv
// r15_trace_capture
// Reader side of the core's R15output/out pair. Samples R15 (program counter)
// and the out bus every enabled cycle, logs each R15 change into a FIFO, and
// tags any non-sequential step (a taken jumpTo) as a discontinuity. A host
// drains the FIFO over a simple rd_en / rd_valid handshake. Never drives the core.
//
// Ports
//   clock       rising-edge clock, shared with the core
//   reset_n     asynchronous active-low reset
//   clear       synchronous flush of FIFO, overflow flag and R15 history
//   capture_en  1 = sample r15_in/out_in this cycle
//   r15_in      core R15output
//   out_in      core out bus
//   rd_en       pop request (ignored while empty)
//   rd_data     {disc, out, r15} of the most recently popped entry
//   rd_valid    one-cycle pulse: rd_data was just loaded by a pop
//   empty/full  registered status, count == 0 / count == DEPTH
//   count       entries held
//   overflow    sticky: a push was dropped because the FIFO was full
module r15_trace_capture #(
  parameter  int DEPTH = 16,
  parameter  int DW    = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            clear,
  input  logic            capture_en,
  input  logic [DW-1:0]   r15_in,
  input  logic [DW-1:0]   out_in,
  input  logic            rd_en,
  output logic [2*DW:0]   rd_data,
  output logic            rd_valid,
  output logic            empty,
  output logic            full,
  output logic [AW:0]     count,
  output logic            overflow
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [2*DW:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [DW-1:0] prev_r15;
  logic          prev_valid;

  logic [DW-1:0] r15_seq;
  logic          push_req, disc, push, pop, drop;
  logic [AW:0]   count_next;

  // Push/pop decisions. clear overrides both so nothing moves during a flush.
  always_comb begin
    r15_seq  = prev_r15 + DW'(1);   // wraps mod 2^DW, so FF -> 00 is sequential
    push_req = capture_en && (!prev_valid || (r15_in != prev_r15));
    disc     = prev_valid && (r15_in != r15_seq);
    pop      = !clear && rd_en && !empty;
    // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
    push     = !clear && push_req && (!full || pop);
    drop     = !clear && push_req && full && !pop;

    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + (AW + 1)'(1);
      2'b01:   count_next = count - (AW + 1)'(1);
      default: count_next = count;
    endcase
  end

  // NOTE: the storage array has no reset; only pointers and count define which
  // entries are meaningful, and leaving it unreset lets it map onto RAM.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= {disc, out_in, r15_in};
  end

  // NOTE: all state uses non-blocking assignments so the read of mem[rd_ptr]
  // sees the pre-edge contents even when a push hits the same slot.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      empty      <= 1'b1;
      full       <= 1'b0;
      overflow   <= 1'b0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      prev_r15   <= '0;
      prev_valid <= 1'b0;
    end else if (clear) begin
      // rd_data and prev_r15 deliberately hold; prev_valid=0 makes prev_r15 moot.
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      empty      <= 1'b1;
      full       <= 1'b0;
      overflow   <= 1'b0;
      rd_valid   <= 1'b0;
      prev_valid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr  <= rd_ptr + AW'(1);
        rd_data <= mem[rd_ptr];
      end
      rd_valid <= pop;
      count    <= count_next;
      empty    <= (count_next == '0);
      full     <= (count_next == FULL_CNT);
      if (drop) overflow <= 1'b1;

      // History tracks every enabled sample, including dropped pushes.
      prev_valid <= capture_en;
      if (capture_en) prev_r15 <= r15_in;
    end
  end

endmodule

// File: tb/tb_r15_trace_capture.sv
// Directed testbench for r15_trace_capture (DEPTH=16, DW=8).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_r15_trace_capture;

  logic        clock;
  logic        reset_n;
  logic        clear;
  logic        capture_en;
  logic [7:0]  r15_in;
  logic [7:0]  out_in;
  logic        rd_en;
  logic [16:0] rd_data;
  logic        rd_valid;
  logic        empty;
  logic        full;
  logic [4:0]  count;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  // {rd_valid, count, empty, full, overflow}
  logic [8:0] stat;
  assign stat = {rd_valid, count, empty, full, overflow};

  r15_trace_capture #(.DEPTH(16), .DW(8)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear      (clear),
    .capture_en (capture_en),
    .r15_in     (r15_in),
    .out_in     (out_in),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .empty      (empty),
    .full       (full),
    .count      (count),
    .overflow   (overflow)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    #12;
    total++;
    if (stat !== {1'b0, 5'd0, 1'b1, 1'b0, 1'b0}) begin
      bad++; $display("FAIL reset_status: got %b want %b", stat, {1'b0, 5'd0, 1'b1, 1'b0, 1'b0});
    end
    total++;
    if (rd_data !== 17'd0) begin
      bad++; $display("FAIL reset_rd_data: got %h want %h", rd_data, 17'd0);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_sequential();
    logic [16:0] exp;
    capture_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      r15_in = 8'(i);
      out_in = 8'(8'hA0 + i);
      tick();
      total++;
      if (count !== 5'(i + 1)) begin
        bad++; $display("FAIL seq_fill_count[%0d]: got %0d want %0d", i, count, i + 1);
      end
    end
    capture_en = 1'b0;
    rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp = {1'b0, 8'(8'hA0 + i), 8'(i)};
      total++;
      if (rd_valid !== 1'b1 || rd_data !== exp) begin
        bad++; $display("FAIL seq_pop[%0d]: got v=%b d=%h want v=1 d=%h", i, rd_valid, rd_data, exp);
      end
    end
    rd_en = 1'b0;
    tick();
    total++;
    if (stat !== {1'b0, 5'd0, 1'b1, 1'b0, 1'b0} || rd_data !== {1'b0, 8'hA3, 8'h03}) begin
      bad++; $display("FAIL seq_after_drain: got %b d=%h want %b d=%h", stat, rd_data,
                      {1'b0, 5'd0, 1'b1, 1'b0, 1'b0}, {1'b0, 8'hA3, 8'h03});
    end
    // rd_en while empty is ignored
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    total++;
    if (stat !== {1'b0, 5'd0, 1'b1, 1'b0, 1'b0}) begin
      bad++; $display("FAIL empty_read: got %b want %b", stat, {1'b0, 5'd0, 1'b1, 1'b0, 1'b0});
    end
  endtask

  task automatic test_jump();
    logic [7:0]  r15s [3];
    logic [7:0]  outs [3];
    logic [2:0]  discs;
    logic [16:0] exp;
    r15s = '{8'h04, 8'h05, 8'h03};
    outs = '{8'h11, 8'h22, 8'h33};
    discs = 3'b100;  // bit i = disc of entry i
    capture_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      r15_in = r15s[i];
      out_in = outs[i];
      tick();
    end
    capture_en = 1'b0;
    rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp = {discs[i], outs[i], r15s[i]};
      total++;
      if (rd_valid !== 1'b1 || rd_data !== exp) begin
        bad++; $display("FAIL jump_pop[%0d]: got v=%b d=%h want v=1 d=%h", i, rd_valid, rd_data, exp);
      end
    end
    rd_en = 1'b0;
    tick();
  endtask

  task automatic test_hold_and_wrap();
    logic [7:0]  r15s [4];
    logic [16:0] exp;
    capture_en = 1'b1;
    r15_in = 8'h07;
    out_in = 8'h77;
    repeat (5) tick();
    capture_en = 1'b0;
    total++;
    if (stat !== {1'b0, 5'd1, 1'b0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL hold_count: got %b want %b", stat, {1'b0, 5'd1, 1'b0, 1'b0, 1'b0});
    end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    total++;
    if (rd_valid !== 1'b1 || rd_data !== {1'b0, 8'h77, 8'h07}) begin
      bad++; $display("FAIL hold_pop: got v=%b d=%h want v=1 d=%h", rd_valid, rd_data, {1'b0, 8'h77, 8'h07});
    end

    // FE, FF, 00 sequential; then a gap with capture off before 09
    r15s = '{8'hFE, 8'hFF, 8'h00, 8'h09};
    capture_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      r15_in = r15s[i];
      out_in = 8'(i + 1);
      tick();
    end
    capture_en = 1'b0;
    tick();
    capture_en = 1'b1;
    r15_in = 8'h09;
    out_in = 8'h04;
    tick();
    capture_en = 1'b0;
    total++;
    if (count !== 5'd4) begin
      bad++; $display("FAIL wrap_count: got %0d want 4", count);
    end
    rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp = {1'b0, 8'(i + 1), r15s[i]};
      total++;
      if (rd_valid !== 1'b1 || rd_data !== exp) begin
        bad++; $display("FAIL wrap_pop[%0d]: got v=%b d=%h want v=1 d=%h", i, rd_valid, rd_data, exp);
      end
    end
    rd_en = 1'b0;
    tick();
  endtask

  task automatic test_overflow();
    logic [7:0]  v;
    logic [16:0] exp;
    capture_en = 1'b1;
    for (int i = 0; i < 17; i++) begin
      v = 8'(2 * i);
      r15_in = v;
      out_in = v ^ 8'h5A;
      tick();
    end
    total++;
    if (stat !== {1'b0, 5'd16, 1'b0, 1'b1, 1'b1}) begin
      bad++; $display("FAIL ovf_full: got %b want %b", stat, {1'b0, 5'd16, 1'b0, 1'b1, 1'b1});
    end
    // Full + push + pop: both happen, count stays 16
    r15_in = 8'h80;
    out_in = 8'h80 ^ 8'h5A;
    rd_en = 1'b1;
    tick();
    capture_en = 1'b0;
    total++;
    if (stat !== {1'b1, 5'd16, 1'b0, 1'b1, 1'b1} || rd_data !== {1'b0, 8'h5A, 8'h00}) begin
      bad++; $display("FAIL ovf_push_pop: got %b d=%h want %b d=%h", stat, rd_data,
                      {1'b1, 5'd16, 1'b0, 1'b1, 1'b1}, {1'b0, 8'h5A, 8'h00});
    end
    // Remaining: 2..30 (all jumps of +2), then 0x80; value 32 was dropped
    for (int j = 1; j < 16; j++) begin
      tick();
      v = 8'(2 * j);
      exp = {1'b1, v ^ 8'h5A, v};
      total++;
      if (rd_valid !== 1'b1 || rd_data !== exp) begin
        bad++; $display("FAIL ovf_pop[%0d]: got v=%b d=%h want v=1 d=%h", j, rd_valid, rd_data, exp);
      end
    end
    tick();
    total++;
    if (rd_valid !== 1'b1 || rd_data !== {1'b1, 8'hDA, 8'h80}) begin
      bad++; $display("FAIL ovf_pop_last: got v=%b d=%h want v=1 d=%h", rd_valid, rd_data, {1'b1, 8'hDA, 8'h80});
    end
    rd_en = 1'b0;
    tick();
    total++;
    if (stat !== {1'b0, 5'd0, 1'b1, 1'b0, 1'b1}) begin
      bad++; $display("FAIL ovf_sticky: got %b want %b", stat, {1'b0, 5'd0, 1'b1, 1'b0, 1'b1});
    end
  endtask

  task automatic test_async_reset();
    capture_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      r15_in = 8'(8'h40 + 2 * i);
      out_in = 8'(i);
      tick();
    end
    capture_en = 1'b0;
    total++;
    if (stat !== {1'b0, 5'd5, 1'b0, 1'b0, 1'b1}) begin
      bad++; $display("FAIL areset_pre: got %b want %b", stat, {1'b0, 5'd5, 1'b0, 1'b0, 1'b1});
    end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (stat !== {1'b0, 5'd0, 1'b1, 1'b0, 1'b0} || rd_data !== 17'd0) begin
      bad++; $display("FAIL areset_now: got %b d=%h want %b d=%h", stat, rd_data,
                      {1'b0, 5'd0, 1'b1, 1'b0, 1'b0}, 17'd0);
    end
    #2 reset_n = 1'b1;
    tick();
  endtask

  task automatic test_clear();
    capture_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      r15_in = 8'(8'h50 + i);
      out_in = 8'h00;
      tick();
    end
    total++;
    if (count !== 5'd3) begin
      bad++; $display("FAIL clear_pre_count: got %0d want 3", count);
    end
    clear  = 1'b1;
    r15_in = 8'h60;
    rd_en  = 1'b1;
    tick();
    clear = 1'b0;
    rd_en = 1'b0;
    total++;
    if (stat !== {1'b0, 5'd0, 1'b1, 1'b0, 1'b0} || rd_data !== 17'd0) begin
      bad++; $display("FAIL clear_priority: got %b d=%h want %b d=%h", stat, rd_data,
                      {1'b0, 5'd0, 1'b1, 1'b0, 1'b0}, 17'd0);
    end
    // History was flushed: next sample is a fresh start, disc=0
    r15_in = 8'h70;
    out_in = 8'h33;
    tick();
    capture_en = 1'b0;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    total++;
    if (rd_valid !== 1'b1 || rd_data !== {1'b0, 8'h33, 8'h70}) begin
      bad++; $display("FAIL clear_first_sample: got v=%b d=%h want v=1 d=%h", rd_valid, rd_data, {1'b0, 8'h33, 8'h70});
    end
  endtask

  task automatic test_back_to_back();
    // Empty + push + rd_en: no bypass
    capture_en = 1'b1;
    r15_in = 8'h90;
    out_in = 8'h01;
    rd_en  = 1'b1;
    tick();
    total++;
    if (stat !== {1'b0, 5'd1, 1'b0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL b2b_no_bypass: got %b want %b", stat, {1'b0, 5'd1, 1'b0, 1'b0, 1'b0});
    end
    r15_in = 8'h91;
    out_in = 8'h02;
    tick();
    total++;
    if (stat !== {1'b1, 5'd1, 1'b0, 1'b0, 1'b0} || rd_data !== {1'b0, 8'h01, 8'h90}) begin
      bad++; $display("FAIL b2b_push_pop: got %b d=%h want %b d=%h", stat, rd_data,
                      {1'b1, 5'd1, 1'b0, 1'b0, 1'b0}, {1'b0, 8'h01, 8'h90});
    end
    capture_en = 1'b0;
    tick();
    rd_en = 1'b0;
    total++;
    if (stat !== {1'b1, 5'd0, 1'b1, 1'b0, 1'b0} || rd_data !== {1'b0, 8'h02, 8'h91}) begin
      bad++; $display("FAIL b2b_last_pop: got %b d=%h want %b d=%h", stat, rd_data,
                      {1'b1, 5'd0, 1'b1, 1'b0, 1'b0}, {1'b0, 8'h02, 8'h91});
    end
    tick();
  endtask

  initial begin
    reset_n    = 1'b0;
    clear      = 1'b0;
    capture_en = 1'b0;
    r15_in     = 8'h00;
    out_in     = 8'h00;
    rd_en      = 1'b0;

    test_reset();
    test_sequential();
    test_jump();
    test_hold_and_wrap();
    test_overflow();
    test_async_reset();
    test_clear();
    test_back_to_back();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
